vram_arbiter: RTL and testbench

Single-port arbiter that shares one sprite/entity `sram` instance between the display pixel-fetch path and a host port (CPU or asset loader). Display reads always win. Host writes are posted into a small FIFO and drained in idle memory cycles. Host reads are single-outstanding and ordered behind all posted writes. The block sits between the scan-out logic and the memory, replacing the direct address/write hookup.

---
 rtl/vram_arbiter.sv | 141 ++++++++++++++
 tb/tb_vram_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the display read path always wins, host writes are posted
// through a small FIFO, and host reads are single-outstanding behind all posted writes.
`timescale 1ns/1ps

module vram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          disp_req,
  input  logic [ADDR_WIDTH-1:0]         disp_addr,
  output logic                          disp_valid,
  output logic [DATA_WIDTH-1:0]         disp_data,
  input  logic                          host_wr_valid,
  output logic                          host_wr_ready,
  input  logic [ADDR_WIDTH-1:0]         host_wr_addr,
  input  logic [DATA_WIDTH-1:0]         host_wr_data,
  input  logic                          host_rd_req,
  input  logic [ADDR_WIDTH-1:0]         host_rd_addr,
  output logic                          host_rd_ack,
  output logic [DATA_WIDTH-1:0]         host_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_write,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {RD_IDLE, RD_PEND, RD_DATA, RD_ACK} rd_state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_DISP, GNT_WR, GNT_RD} gnt_t;

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  rd_state_t             rd_state;
  rd_state_t             rd_next;
  logic [ADDR_WIDTH-1:0] rd_addr;
  gnt_t                  gnt;

  assign fifo_count    = count;
  assign fifo_empty    = (count == '0);
  assign host_wr_ready = (count < CNT_W'(FIFO_DEPTH));
  assign push          = host_wr_valid & host_wr_ready;
  assign pop           = (gnt == GNT_WR);

  assign disp_data     = mem_rdata;
  assign host_rd_ack   = (rd_state == RD_ACK);

  // Fixed-priority grant; reads only go once every posted write has drained
  always_comb begin
    gnt = GNT_NONE;
    if (disp_req) begin
      gnt = GNT_DISP;
    end else if (!fifo_empty) begin
      gnt = GNT_WR;
    end else if (rd_state == RD_PEND) begin
      gnt = GNT_RD;
    end
  end

  // Memory port mux, all zero when nobody owns the cycle
  always_comb begin
    mem_addr  = '0;
    mem_write = 1'b0;
    mem_wdata = '0;
    case (gnt)
      GNT_DISP: mem_addr = disp_addr;
      GNT_WR: begin
        mem_addr  = fifo_addr[rd_ptr];
        mem_write = 1'b1;
        mem_wdata = fifo_data[rd_ptr];
      end
      GNT_RD:   mem_addr = rd_addr;
      default: ;
    endcase
  end

  // Posted-write storage; stale entries are harmless because pointers gate them
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= host_wr_addr;
      fifo_data[wr_ptr] <= host_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_state <= RD_IDLE;
    else     rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (host_rd_req) rd_next = RD_PEND;
      RD_PEND: if (gnt == GNT_RD) rd_next = RD_DATA;
      RD_DATA: rd_next = RD_ACK;
      RD_ACK:  rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr      <= '0;
      host_rd_data <= '0;
      disp_valid   <= 1'b0;
    end else begin
      if (rd_state == RD_IDLE && host_rd_req) rd_addr <= host_rd_addr;
      if (rd_state == RD_DATA) host_rd_data <= mem_rdata;
      disp_valid <= disp_req;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural single-port SRAM behind it.
`timescale 1ns/1ps

module tb_vram_arbiter;

  logic       clk;
  logic       rst;
  logic       disp_req;
  logic [9:0] disp_addr;
  logic       disp_valid;
  logic [7:0] disp_data;
  logic       host_wr_valid;
  logic       host_wr_ready;
  logic [9:0] host_wr_addr;
  logic [7:0] host_wr_data;
  logic       host_rd_req;
  logic [9:0] host_rd_addr;
  logic       host_rd_ack;
  logic [7:0] host_rd_data;
  logic [2:0] fifo_count;
  logic [9:0] mem_addr;
  logic       mem_write;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] sram_q [1024];

  int passed = 0;
  int total  = 0;

  vram_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
    .host_rd_ack(host_rd_ack), .host_rd_data(host_rd_data),
    .fifo_count(fifo_count),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous SRAM: read data one cycle after the address
  always @(posedge clk) begin
    if (mem_write) sram_q[mem_addr] <= mem_wdata;
    mem_rdata <= sram_q[mem_addr];
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; disp_req = 1'b0; disp_addr = '0;
    host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    host_rd_req = 1'b0; host_rd_addr = '0;
    next(); next();
    rst = 1'b0;
    settle();
    total++; if (host_wr_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", host_wr_ready); else passed++;
    total++; if (fifo_count !== 3'd0) $display("FAIL rst_count got %0d want 0", fifo_count); else passed++;
    total++; if (disp_valid !== 1'b0) $display("FAIL rst_disp_valid got %b want 0", disp_valid); else passed++;
    total++; if (host_rd_ack !== 1'b0) $display("FAIL rst_ack got %b want 0", host_rd_ack); else passed++;
    total++; if (host_rd_data !== 8'h00) $display("FAIL rst_rd_data got %h want 00", host_rd_data); else passed++;
    total++; if (mem_addr !== 10'h000) $display("FAIL rst_mem_addr got %h want 000", mem_addr); else passed++;
    total++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write got %b want 0", mem_write); else passed++;
    total++; if (mem_wdata !== 8'h00) $display("FAIL rst_mem_wdata got %h want 00", mem_wdata); else passed++;
    for (int i = 0; i < 3; i++) begin
      next(); settle();
      total++; if (mem_write !== 1'b0) $display("FAIL idle_mem_write cycle %0d got %b want 0", i, mem_write); else passed++;
    end
  endtask

  task automatic test_write_read();
    next();
    host_wr_valid = 1'b1; host_wr_addr = 10'h010; host_wr_data = 8'hA5;
    settle();
    total++; if (host_wr_ready !== 1'b1) $display("FAIL wr_ready got %b want 1", host_wr_ready); else passed++;
    next();
    host_wr_valid = 1'b0;
    settle();
    total++; if (mem_write !== 1'b1) $display("FAIL wr_mem_write got %b want 1", mem_write); else passed++;
    total++; if (mem_addr !== 10'h010) $display("FAIL wr_mem_addr got %h want 010", mem_addr); else passed++;
    total++; if (mem_wdata !== 8'hA5) $display("FAIL wr_mem_wdata got %h want a5", mem_wdata); else passed++;
    total++; if (fifo_count !== 3'd1) $display("FAIL wr_count got %0d want 1", fifo_count); else passed++;
    next();
    host_rd_req = 1'b1; host_rd_addr = 10'h010;
    settle();
    total++; if (fifo_count !== 3'd0) $display("FAIL rd_count got %0d want 0", fifo_count); else passed++;
    next();
    host_rd_req = 1'b0;
    settle();
    total++; if (mem_addr !== 10'h010) $display("FAIL rd_grant_addr got %h want 010", mem_addr); else passed++;
    total++; if (mem_write !== 1'b0) $display("FAIL rd_grant_write got %b want 0", mem_write); else passed++;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) next();
      if (j == 0) next();
      settle();
      total++; if (host_rd_ack !== (j == 1)) $display("FAIL rd_ack step %0d got %b want %b", j, host_rd_ack, (j == 1)); else passed++;
      if (j >= 1) begin
        total++; if (host_rd_data !== 8'hA5) $display("FAIL rd_data step %0d got %h want a5", j, host_rd_data); else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    next();
    disp_req = 1'b1; disp_addr = 10'h3FF; host_wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next();
      host_wr_addr = 10'(32'h100 + i); host_wr_data = 8'(32'h40 + i);
      settle();
      total++; if (host_wr_ready !== (i < 4)) $display("FAIL b2b_ready %0d got %b want %b", i, host_wr_ready, (i < 4)); else passed++;
      total++; if (fifo_count !== 3'(i)) $display("FAIL b2b_count %0d got %0d want %0d", i, fifo_count, i); else passed++;
      total++; if (mem_write !== 1'b0) $display("FAIL b2b_nowrite %0d got %b want 0", i, mem_write); else passed++;
      total++; if (mem_addr !== 10'h3FF) $display("FAIL b2b_disp_addr %0d got %h want 3ff", i, mem_addr); else passed++;
    end
    next();
    disp_req = 1'b0;
    settle();
    total++; if (host_wr_ready !== 1'b0) $display("FAIL drain_full_ready got %b want 0", host_wr_ready); else passed++;
    total++; if (fifo_count !== 3'd4) $display("FAIL drain0_count got %0d want 4", fifo_count); else passed++;
    total++; if (mem_write !== 1'b1 || mem_addr !== 10'h100 || mem_wdata !== 8'h40)
      $display("FAIL drain0 got w=%b a=%h d=%h want w=1 a=100 d=40", mem_write, mem_addr, mem_wdata); else passed++;
    next();
    settle();
    total++; if (host_wr_ready !== 1'b1) $display("FAIL drain1_ready got %b want 1", host_wr_ready); else passed++;
    total++; if (fifo_count !== 3'd3) $display("FAIL drain1_count got %0d want 3", fifo_count); else passed++;
    total++; if (mem_write !== 1'b1 || mem_addr !== 10'h101 || mem_wdata !== 8'h41)
      $display("FAIL drain1 got w=%b a=%h d=%h want w=1 a=101 d=41", mem_write, mem_addr, mem_wdata); else passed++;
    for (int k = 2; k < 5; k++) begin
      next();
      if (k == 2) host_wr_valid = 1'b0;
      settle();
      total++; if (fifo_count !== 3'(5 - k)) $display("FAIL drain%0d_count got %0d want %0d", k, fifo_count, 5 - k); else passed++;
      total++; if (mem_write !== 1'b1 || mem_addr !== 10'(32'h100 + k) || mem_wdata !== 8'(32'h40 + k))
        $display("FAIL drain%0d got w=%b a=%h d=%h want w=1 a=%h d=%h", k, mem_write, mem_addr, mem_wdata, 10'(32'h100 + k), 8'(32'h40 + k)); else passed++;
    end
    next();
    settle();
    total++; if (fifo_count !== 3'd0 || mem_write !== 1'b0) $display("FAIL drain_done got count=%0d w=%b want 0 0", fifo_count, mem_write); else passed++;
  endtask

  task automatic test_read_ordering();
    next();
    disp_req = 1'b1; disp_addr = 10'h000;
    host_wr_valid = 1'b1; host_wr_addr = 10'h020; host_wr_data = 8'h11;
    next(); host_wr_data = 8'h22;
    next(); host_wr_data = 8'h33;
    next();
    host_wr_valid = 1'b0; host_rd_req = 1'b1; host_rd_addr = 10'h020;
    settle();
    total++; if (fifo_count !== 3'd3) $display("FAIL ord_count got %0d want 3", fifo_count); else passed++;
    next();
    host_rd_req = 1'b0; disp_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next();
      settle();
      total++; if (mem_write !== 1'b1 || mem_wdata !== 8'(32'h11 * (k + 1)))
        $display("FAIL ord_drain%0d got w=%b d=%h want w=1 d=%h", k, mem_write, mem_wdata, 8'(32'h11 * (k + 1))); else passed++;
    end
    next(); settle();
    total++; if (mem_write !== 1'b0 || mem_addr !== 10'h020) $display("FAIL ord_grant got w=%b a=%h want w=0 a=020", mem_write, mem_addr); else passed++;
    next(); settle();
    total++; if (host_rd_ack !== 1'b0) $display("FAIL ord_early_ack got %b want 0", host_rd_ack); else passed++;
    next(); settle();
    total++; if (host_rd_ack !== 1'b1 || host_rd_data !== 8'h33) $display("FAIL ord_ack got ack=%b d=%h want 1 33", host_rd_ack, host_rd_data); else passed++;
  endtask

  task automatic test_disp_interleave();
    logic [6:0] pat;
    logic       prev;
    logic [9:0] exp_addr;
    for (int k = 0; k < 7; k++) begin
      next();
      host_wr_valid = 1'b1; host_wr_addr = 10'(32'h030 + k); host_wr_data = 8'(32'hC0 + k);
    end
    next(); host_wr_valid = 1'b0;
    next(); next(); settle();
    total++; if (fifo_count !== 3'd0) $display("FAIL preload_count got %0d want 0", fifo_count); else passed++;
    pat  = 7'b0101011;
    prev = 1'b0;
    for (int c = 0; c < 7; c++) begin
      next();
      disp_req = pat[c]; disp_addr = 10'(32'h030 + c);
      host_rd_req = (c == 0); host_rd_addr = 10'h020;
      settle();
      exp_addr = pat[c] ? 10'(32'h030 + c) : ((c == 2) ? 10'h020 : 10'h000);
      total++; if (mem_addr !== exp_addr || mem_write !== 1'b0)
        $display("FAIL il_mem c%0d got a=%h w=%b want a=%h w=0", c, mem_addr, mem_write, exp_addr); else passed++;
      total++; if (host_rd_ack !== (c == 4)) $display("FAIL il_ack c%0d got %b want %b", c, host_rd_ack, (c == 4)); else passed++;
      total++; if (disp_valid !== prev) $display("FAIL il_disp_valid c%0d got %b want %b", c, disp_valid, prev); else passed++;
      if (prev) begin
        total++; if (disp_data !== 8'(32'hC0 + c - 1)) $display("FAIL il_disp_data c%0d got %h want %h", c, disp_data, 8'(32'hC0 + c - 1)); else passed++;
      end
      if (c == 4) begin
        total++; if (host_rd_data !== 8'h33) $display("FAIL il_rd_data got %h want 33", host_rd_data); else passed++;
      end
      prev = pat[c];
    end
    host_rd_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    next();
    disp_req = 1'b0; host_rd_req = 1'b1; host_rd_addr = 10'h010;
    next();
    host_rd_req = 1'b0;
    host_wr_valid = 1'b1; host_wr_addr = 10'h050; host_wr_data = 8'h77;
    settle();
    total++; if (mem_addr !== 10'h010) $display("FAIL rm_grant got %h want 010", mem_addr); else passed++;
    next();
    disp_req = 1'b1; disp_addr = 10'h000;
    host_wr_addr = 10'h051; host_wr_data = 8'h78; rst = 1'b1;
    settle();
    total++; if (fifo_count !== 3'd1) $display("FAIL rm_pre_count got %0d want 1", fifo_count); else passed++;
    next();
    rst = 1'b0; host_wr_valid = 1'b0; disp_req = 1'b0;
    settle();
    total++; if (fifo_count !== 3'd0) $display("FAIL rm_count got %0d want 0", fifo_count); else passed++;
    total++; if (host_rd_ack !== 1'b0) $display("FAIL rm_ack got %b want 0", host_rd_ack); else passed++;
    total++; if (mem_write !== 1'b0) $display("FAIL rm_mem_write got %b want 0", mem_write); else passed++;
    total++; if (disp_valid !== 1'b0) $display("FAIL rm_disp_valid got %b want 0", disp_valid); else passed++;
    total++; if (host_rd_data !== 8'h00) $display("FAIL rm_rd_data got %h want 00", host_rd_data); else passed++;
    total++; if (host_wr_ready !== 1'b1) $display("FAIL rm_ready got %b want 1", host_wr_ready); else passed++;
    next(); settle();
    total++; if (host_rd_ack !== 1'b0 || mem_write !== 1'b0) $display("FAIL rm_quiet got ack=%b w=%b want 0 0", host_rd_ack, mem_write); else passed++;
    next();
    host_rd_req = 1'b1; host_rd_addr = 10'h010;
    for (int j = 1; j < 9; j++) begin
      next();
      if (j == 5) host_rd_req = 1'b0;
      settle();
      total++; if (host_rd_ack !== (j == 3 || j == 7))
        $display("FAIL fresh_ack j%0d got %b want %b", j, host_rd_ack, (j == 3 || j == 7)); else passed++;
      total++; if (mem_addr !== ((j == 1 || j == 5) ? 10'h010 : 10'h000))
        $display("FAIL fresh_addr j%0d got %h want %h", j, mem_addr, ((j == 1 || j == 5) ? 10'h010 : 10'h000)); else passed++;
      if (j == 3 || j == 7) begin
        total++; if (host_rd_data !== 8'hA5) $display("FAIL fresh_data j%0d got %h want a5", j, host_rd_data); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_read_ordering();
    test_disp_interleave();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
